// File: rtl/ucmd_dec_param.sv
// UART command decoder: pops RX bytes, optionally echoes them, matches single-char
// commands against a table and collects "#digits<CR>" decimal arguments.
//
// state  | meaning
// IDLE   | waiting for an RX byte (fetch allowed)
// DEC    | decode a byte fetched in IDLE
// ARG    | collecting argument digits, inter-byte timeout running (fetch allowed)
// ADEC   | decode a byte fetched in ARG
module ucmd_dec_param #(
    parameter int                NCMD       = 10,
    parameter logic [NCMD*8-1:0] CMD_TABLE  = "CFM-+LRcsr",
    parameter logic [7:0]        PREFIX     = "#",
    parameter logic [7:0]        TERM       = 8'h0D,
    parameter int                ARG_DIGITS = 4,
    parameter int                ARG_W      = 14,
    parameter int                TO_CYC     = 100000000,
    parameter bit                ECHO       = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_empty,
    output logic             rx_pop,
    output logic [7:0]       tx_data,
    input  logic             tx_full,
    output logic             tx_push,
    output logic [NCMD-1:0]  cmd_pulse,
    output logic [ARG_W-1:0] arg_value,
    output logic             arg_valid,
    output logic             err_pulse,
    output logic             busy
);

    localparam int TO_W  = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam int CNT_W = $clog2(ARG_DIGITS + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TO_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ARG_DIGITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEC,
        S_ARG,
        S_ADEC
    } state_t;

    state_t           state;
    logic [7:0]       byte_q;
    logic [ARG_W-1:0] acc;
    logic [CNT_W-1:0] dig_cnt;
    logic [TO_W-1:0]  to_cnt;

    logic             fetch;
    logic             tbl_hit;
    logic [NCMD-1:0]  tbl_vec;
    logic             is_digit;
    logic [ARG_W+3:0] acc_mul;
    logic [ARG_W-1:0] acc_next;

    // Pop and echo share one cycle; with echo off a full TX FIFO cannot stall us.
    assign fetch   = !rst && (state == S_IDLE || state == S_ARG) && !rx_empty
                     && (!tx_full || !ECHO);
    assign rx_pop  = fetch;
    assign tx_push = ECHO ? fetch : 1'b0;
    assign tx_data = rx_data;

    // Descending scan so the lowest matching channel is the one left standing.
    always_comb begin
        tbl_hit = 1'b0;
        tbl_vec = '0;
        for (int k = NCMD - 1; k >= 0; k--) begin
            if (byte_q == CMD_TABLE[8*k +: 8]) begin
                tbl_hit    = 1'b1;
                tbl_vec    = '0;
                tbl_vec[k] = 1'b1;
            end
        end
    end

    assign is_digit = (byte_q >= 8'h30) && (byte_q <= 8'h39);
    assign acc_mul  = ({4'b0000, acc} * (ARG_W+4)'(10)) + (ARG_W+4)'(byte_q[3:0]);
    assign acc_next = acc_mul[ARG_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            byte_q    <= '0;
            acc       <= '0;
            dig_cnt   <= '0;
            to_cnt    <= '0;
            cmd_pulse <= '0;
            arg_value <= '0;
            arg_valid <= 1'b0;
            err_pulse <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cmd_pulse <= '0;
            arg_valid <= 1'b0;
            err_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fetch) begin
                        byte_q <= rx_data;
                        state  <= S_DEC;
                    end
                end
                S_DEC: begin
                    if (byte_q == PREFIX) begin
                        acc     <= '0;
                        dig_cnt <= '0;
                        to_cnt  <= '0;
                        busy    <= 1'b1;
                        state   <= S_ARG;
                    end else if (tbl_hit) begin
                        cmd_pulse <= tbl_vec;
                        state     <= S_IDLE;
                    end else begin
                        err_pulse <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_ARG: begin
                    if (fetch) begin
                        byte_q <= rx_data;
                        to_cnt <= '0;
                        state  <= S_ADEC;
                    end else if (to_cnt == TO_LAST) begin
                        err_pulse <= 1'b1;
                        busy      <= 1'b0;
                        acc       <= '0;
                        dig_cnt   <= '0;
                        to_cnt    <= '0;
                        state     <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_ADEC: begin
                    if (is_digit && dig_cnt < CNT_MAX) begin
                        acc     <= acc_next;
                        dig_cnt <= dig_cnt + 1'b1;
                        state   <= S_ARG;
                    end else if (byte_q == TERM && dig_cnt != '0) begin
                        arg_value <= acc;
                        arg_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        err_pulse <= 1'b1;
                        busy      <= 1'b0;
                        acc       <= '0;
                        dig_cnt   <= '0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ucmd_dec_param.sv
// Directed bench for ucmd_dec_param: an echoing instance with a short timeout and
// a non-echoing instance, each fed from a small RX FIFO model.
module tb_ucmd_dec_param;

    localparam int NCMD  = 10;
    localparam int ARG_W = 14;
    localparam logic [7:0] CR = 8'h0D;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]       rx_data, tx_data;
    logic             rx_empty, rx_pop, tx_full, tx_push;
    logic [NCMD-1:0]  cmd_pulse;
    logic [ARG_W-1:0] arg_value;
    logic             arg_valid, err_pulse, busy;

    logic [7:0]       rx_data_2, tx_data_2;
    logic             rx_empty_2, rx_pop_2, tx_full_2, tx_push_2;
    logic [NCMD-1:0]  cmd_pulse_2;
    logic [ARG_W-1:0] arg_value_2;
    logic             arg_valid_2, err_pulse_2, busy_2;

    ucmd_dec_param #(.TO_CYC(50), .ECHO(1'b1)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_empty(rx_empty), .rx_pop(rx_pop),
        .tx_data(tx_data), .tx_full(tx_full), .tx_push(tx_push),
        .cmd_pulse(cmd_pulse), .arg_value(arg_value), .arg_valid(arg_valid),
        .err_pulse(err_pulse), .busy(busy)
    );

    ucmd_dec_param #(.TO_CYC(50), .ECHO(1'b0)) dut_ne (
        .clk(clk), .rst(rst),
        .rx_data(rx_data_2), .rx_empty(rx_empty_2), .rx_pop(rx_pop_2),
        .tx_data(tx_data_2), .tx_full(tx_full_2), .tx_push(tx_push_2),
        .cmd_pulse(cmd_pulse_2), .arg_value(arg_value_2), .arg_valid(arg_valid_2),
        .err_pulse(err_pulse_2), .busy(busy_2)
    );

    // Show-ahead RX FIFO models
    logic [7:0] fifo_mem  [0:63];
    logic [7:0] fifo_mem2 [0:63];
    logic [5:0] wr_ptr = '0, rd_ptr = '0, wr_ptr2 = '0, rd_ptr2 = '0;
    assign rx_data    = fifo_mem[rd_ptr];
    assign rx_empty   = (wr_ptr == rd_ptr);
    assign rx_data_2  = fifo_mem2[rd_ptr2];
    assign rx_empty_2 = (wr_ptr2 == rd_ptr2);

    int n_pop = 0, n_push = 0, n_b2b = 0, n_cmd = 0, n_err = 0, n_argv = 0;
    int n_multi = 0, n_busy = 0, n_push_mis = 0;
    int n_pop2 = 0, n_push2 = 0, n_cmd2 = 0, n_err2 = 0;
    logic [NCMD-1:0] last_cmd = '0;
    logic [7:0] push_log [0:63];
    logic pop_d = 1'b0;

    always @(posedge clk) begin
        pop_d <= rx_pop;
        if (rx_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            n_pop  <= n_pop + 1;
            if (pop_d) n_b2b <= n_b2b + 1;
        end
        if (tx_push) begin
            push_log[n_push[5:0]] <= tx_data;
            n_push <= n_push + 1;
        end
        if (tx_push != rx_pop) n_push_mis <= n_push_mis + 1;
        if (cmd_pulse != '0) begin
            n_cmd    <= n_cmd + 1;
            last_cmd <= cmd_pulse;
        end
        if (err_pulse) n_err <= n_err + 1;
        if (arg_valid) n_argv <= n_argv + 1;
        if (busy) n_busy <= n_busy + 1;
        if (($countones(cmd_pulse) + 32'(arg_valid) + 32'(err_pulse)) > 1)
            n_multi <= n_multi + 1;
        if (rx_pop_2) begin
            rd_ptr2 <= rd_ptr2 + 1'b1;
            n_pop2  <= n_pop2 + 1;
        end
        if (tx_push_2) n_push2 <= n_push2 + 1;
        if (cmd_pulse_2 != '0) n_cmd2 <= n_cmd2 + 1;
        if (err_pulse_2) n_err2 <= n_err2 + 1;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 1'b1;
    endtask

    task automatic put2(input logic [7:0] b);
        fifo_mem2[wr_ptr2] = b;
        wr_ptr2 = wr_ptr2 + 1'b1;
    endtask

    task automatic put_str(input string s);
        for (int i = 0; i < s.len(); i++) put(s[i]);
    endtask

    task automatic test_reset;
        rst = 1'b1; tx_full = 1'b0; tx_full_2 = 1'b1;
        cyc(2);
        put("c");
        #1;
        n_cmp++; if (rx_pop !== 1'b0) begin n_fail++; $display("FAIL reset_rx_pop got %0b want 0", rx_pop); end
        n_cmp++; if (tx_push !== 1'b0) begin n_fail++; $display("FAIL reset_tx_push got %0b want 0", tx_push); end
        n_cmp++; if (cmd_pulse !== '0) begin n_fail++; $display("FAIL reset_cmd got %h want 0", cmd_pulse); end
        n_cmp++; if (arg_value !== '0) begin n_fail++; $display("FAIL reset_arg_value got %0d want 0", arg_value); end
        n_cmp++; if ({busy, arg_valid, err_pulse} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {busy, arg_valid, err_pulse}); end
        cyc(1);
        rst = 1'b0;
        #1;
        n_cmp++; if (rx_pop !== 1'b1) begin n_fail++; $display("FAIL first_pop got %0b want 1", rx_pop); end
        cyc(2);
        n_cmp++; if (cmd_pulse !== 10'h004) begin n_fail++; $display("FAIL first_cmd got %h want 004", cmd_pulse); end
        cyc(2);
    endtask

    task automatic test_single_cmd;
        logic [7:0]      bs  [2] = '{"r", "C"};
        logic [NCMD-1:0] exp [2] = '{10'h001, 10'h200};
        int e;
        for (int i = 0; i < 2; i++) begin
            e = n_err;
            put(bs[i]);
            #1;
            n_cmp++; if (rx_pop !== 1'b1) begin n_fail++; $display("FAIL cmd_pop[%0d] got %0b want 1", i, rx_pop); end
            n_cmp++; if (tx_push !== 1'b1 || tx_data !== bs[i]) begin n_fail++; $display("FAIL cmd_echo[%0d] got %0b/%h want 1/%h", i, tx_push, tx_data, bs[i]); end
            cyc(1);
            n_cmp++; if (cmd_pulse !== '0) begin n_fail++; $display("FAIL cmd_early[%0d] got %h want 0", i, cmd_pulse); end
            cyc(1);
            n_cmp++; if (cmd_pulse !== exp[i]) begin n_fail++; $display("FAIL cmd_pulse[%0d] got %h want %h", i, cmd_pulse, exp[i]); end
            cyc(1);
            n_cmp++; if (cmd_pulse !== '0) begin n_fail++; $display("FAIL cmd_width[%0d] got %h want 0", i, cmd_pulse); end
            n_cmp++; if (n_err != e) begin n_fail++; $display("FAIL cmd_no_err[%0d] got %0d want 0", i, n_err - e); end
        end
    endtask

    task automatic test_errors;
        int e = n_err, c = n_cmd, p = n_push;
        put("7"); put("x");
        cyc(8);
        n_cmp++; if (n_err - e != 2) begin n_fail++; $display("FAIL err_count got %0d want 2", n_err - e); end
        n_cmp++; if (n_cmd != c) begin n_fail++; $display("FAIL err_no_cmd got %0d want 0", n_cmd - c); end
        n_cmp++; if (n_push - p != 2) begin n_fail++; $display("FAIL err_pushes got %0d want 2", n_push - p); end
        n_cmp++; if (push_log[p[5:0]] !== "7" || push_log[p[5:0] + 6'd1] !== "x") begin n_fail++; $display("FAIL err_echo got %h %h want 37 78", push_log[p[5:0]], push_log[p[5:0] + 6'd1]); end
    endtask

    task automatic test_arg;
        int b = n_busy;
        int k;
        put_str("#123"); put(CR);
        cyc(3);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL arg_busy got %0b want 1", busy); end
        k = 0;
        while (arg_valid !== 1'b1 && k < 60) begin cyc(1); k++; end
        n_cmp++; if (arg_valid !== 1'b1) begin n_fail++; $display("FAIL arg_valid_timeout got %0b want 1", arg_valid); end
        n_cmp++; if (arg_value !== 14'd123) begin n_fail++; $display("FAIL arg_123 got %0d want 123", arg_value); end
        n_cmp++; if (n_busy - b < 8) begin n_fail++; $display("FAIL arg_busy_cycles got %0d want >=8", n_busy - b); end
        cyc(1);
        n_cmp++; if (arg_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL arg_after got %0b/%0b want 0/0", arg_valid, busy); end
        put_str("#0042"); put(CR);
        k = 0;
        while (arg_valid !== 1'b1 && k < 60) begin cyc(1); k++; end
        n_cmp++; if (arg_valid !== 1'b1 || arg_value !== 14'd42) begin n_fail++; $display("FAIL arg_42 got %0b/%0d want 1/42", arg_valid, arg_value); end
        cyc(2);
    endtask

    task automatic test_arg_errors;
        int e = n_err, c = n_cmd, a = n_argv;
        put_str("#1r");
        cyc(12);
        n_cmp++; if (n_err - e != 1) begin n_fail++; $display("FAIL argr_err got %0d want 1", n_err - e); end
        n_cmp++; if (n_cmd != c) begin n_fail++; $display("FAIL argr_no_cmd got %0d want 0", n_cmd - c); end
        e = n_err;
        put_str("#12345"); put(CR);
        cyc(30);
        n_cmp++; if (n_err - e != 2) begin n_fail++; $display("FAIL arg5_err got %0d want 2", n_err - e); end
        n_cmp++; if (n_argv != a) begin n_fail++; $display("FAIL arg5_no_valid got %0d want 0", n_argv - a); end
        n_cmp++; if (arg_value !== 14'd42) begin n_fail++; $display("FAIL arg5_value got %0d want 42", arg_value); end
        e = n_err;
        put("#"); put(CR);
        cyc(10);
        n_cmp++; if (n_err - e != 1 || n_argv != a) begin n_fail++; $display("FAIL arg_empty got err %0d valid %0d want 1/0", n_err - e, n_argv - a); end
    endtask

    task automatic test_tx_full;
        int p0 = n_pop, q0 = n_push, c0 = n_cmd;
        tx_full = 1'b1;
        put_str("sRL");
        cyc(10);
        #1;
        n_cmp++; if (n_pop != p0 || rx_pop !== 1'b0) begin n_fail++; $display("FAIL full_no_pop got %0d/%0b want 0/0", n_pop - p0, rx_pop); end
        tx_full = 1'b0;
        cyc(20);
        n_cmp++; if (n_pop - p0 != 3 || n_push - q0 != 3) begin n_fail++; $display("FAIL full_release got pop %0d push %0d want 3/3", n_pop - p0, n_push - q0); end
        n_cmp++; if (n_b2b != 0 || n_push_mis != 0) begin n_fail++; $display("FAIL full_b2b got b2b %0d mis %0d want 0/0", n_b2b, n_push_mis); end
        n_cmp++; if (n_cmd - c0 != 3 || last_cmd !== 10'h010) begin n_fail++; $display("FAIL full_cmds got %0d/%h want 3/010", n_cmd - c0, last_cmd); end
        n_cmp++; if (n_multi != 0) begin n_fail++; $display("FAIL strobe_overlap got %0d want 0", n_multi); end
    endtask

    task automatic test_no_echo;
        put2("s"); put2("R"); put2("L");
        cyc(20);
        n_cmp++; if (n_pop2 != 3) begin n_fail++; $display("FAIL noecho_pops got %0d want 3", n_pop2); end
        n_cmp++; if (n_push2 != 0) begin n_fail++; $display("FAIL noecho_push got %0d want 0", n_push2); end
        n_cmp++; if (n_cmd2 != 3 || n_err2 != 0) begin n_fail++; $display("FAIL noecho_cmds got %0d/%0d want 3/0", n_cmd2, n_err2); end
        n_cmp++; if (busy_2 !== 1'b0 || arg_valid_2 !== 1'b0 || arg_value_2 !== '0 || tx_data_2 !== rx_data_2) begin n_fail++; $display("FAIL noecho_idle got %0b/%0b/%0d want 0/0/0", busy_2, arg_valid_2, arg_value_2); end
    endtask

    task automatic test_timeout;
        put_str("#12");
        cyc(55);
        n_cmp++; if (busy !== 1'b1 || err_pulse !== 1'b0) begin n_fail++; $display("FAIL to_early got busy %0b err %0b want 1/0", busy, err_pulse); end
        cyc(1);
        n_cmp++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL to_err got %0b want 1", err_pulse); end
        n_cmp++; if (busy !== 1'b0 || arg_value !== 14'd42) begin n_fail++; $display("FAIL to_after got busy %0b val %0d want 0/42", busy, arg_value); end
        put("M");
        cyc(2);
        n_cmp++; if (cmd_pulse !== 10'h080) begin n_fail++; $display("FAIL to_then_M got %h want 080", cmd_pulse); end
        cyc(2);
    endtask

    task automatic test_reset_mid_arg;
        int k;
        put_str("#4");
        cyc(4);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %0b want 1", busy); end
        rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0 || arg_value !== '0) begin n_fail++; $display("FAIL mid_reset got busy %0b val %0d want 0/0", busy, arg_value); end
        cyc(2);
        rst = 1'b0;
        put_str("#9"); put(CR);
        k = 0;
        while (arg_valid !== 1'b1 && k < 40) begin cyc(1); k++; end
        n_cmp++; if (arg_valid !== 1'b1 || arg_value !== 14'd9) begin n_fail++; $display("FAIL mid_arg9 got %0b/%0d want 1/9", arg_valid, arg_value); end
        cyc(2);
    endtask

    initial begin
        test_reset;
        test_single_cmd;
        test_errors;
        test_arg;
        test_arg_errors;
        test_tx_full;
        test_no_echo;
        test_timeout;
        test_reset_mid_arg;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
